// File: rtl/snax_exercise_out_serializer.sv
// Output serializer for the exercise accelerator PE.
// Buffers 2*DataWidth results in a small FIFO and emits each one as two
// DataWidth beats (low half first) toward the data-streamer write port,
// tracking per-job progress against a CSR-supplied result count.
module snax_exercise_out_serializer #(
    parameter int DataWidth    = 64,
    parameter int RegDataWidth = 32,
    parameter int FifoDepth    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [RegDataWidth-1:0]   len_i,
    input  logic [2*DataWidth-1:0]    res_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    output logic [DataWidth-1:0]      wr_data_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [RegDataWidth-1:0]   beat_count_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Registered state
    state_t                    state_r;
    logic [2*DataWidth-1:0]    mem_r [FifoDepth];
    logic [PtrW-1:0]           wr_ptr_r;
    logic [PtrW-1:0]           rd_ptr_r;
    logic [CntW-1:0]           count_r;
    logic                      beat_sel_r;
    logic [RegDataWidth-1:0]   len_r;
    logic [RegDataWidth-1:0]   accepted_r;
    logic [RegDataWidth-1:0]   emitted_r;
    logic [RegDataWidth-1:0]   beat_count_r;
    logic                      done_r;

    // Next-state values
    state_t                    state_s;
    logic [CntW-1:0]           count_s;
    logic                      beat_sel_s;
    logic [RegDataWidth-1:0]   len_s;
    logic [RegDataWidth-1:0]   accepted_s;
    logic [RegDataWidth-1:0]   emitted_s;
    logic [RegDataWidth-1:0]   beat_count_s;
    logic                      done_s;

    // Handshake / status decode
    logic fifo_full_s;
    logic fifo_empty_s;
    logic push_s;
    logic beat_hs_s;
    logic pop_s;

    assign fifo_full_s  = (count_r == CntW'(FifoDepth));
    assign fifo_empty_s = (count_r == CntW'(0));

    // Ready depends only on registered state: no push-when-full bypass.
    assign res_ready_o  = (state_r == RUN) && !fifo_full_s && (accepted_r < len_r);
    assign wr_valid_o   = !fifo_empty_s;
    assign wr_data_o    = beat_sel_r ? mem_r[rd_ptr_r][2*DataWidth-1:DataWidth]
                                     : mem_r[rd_ptr_r][DataWidth-1:0];
    assign busy_o       = (state_r == RUN);
    assign done_o       = done_r;
    assign beat_count_o = beat_count_r;

    assign push_s    = res_valid_i && res_ready_o;
    assign beat_hs_s = wr_valid_o && wr_ready_i;
    assign pop_s     = beat_hs_s && beat_sel_r;

    // Next-state logic: job FSM, progress counters and FIFO occupancy.
    always_comb begin
        state_s      = state_r;
        done_s       = 1'b0;
        len_s        = len_r;
        accepted_s   = accepted_r + RegDataWidth'(push_s);
        emitted_s    = emitted_r + RegDataWidth'(pop_s);
        beat_count_s = beat_count_r + RegDataWidth'(beat_hs_s);
        beat_sel_s   = beat_sel_r ^ beat_hs_s;

        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CntW'(1);
            2'b01:   count_s = count_r - CntW'(1);
            default: count_s = count_r;
        endcase

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    beat_count_s = {RegDataWidth{1'b0}};
                    if (len_i != {RegDataWidth{1'b0}}) begin
                        state_s    = RUN;
                        len_s      = len_i;
                        accepted_s = {RegDataWidth{1'b0}};
                        emitted_s  = {RegDataWidth{1'b0}};
                        beat_sel_s = 1'b0;
                    end else begin
                        // Empty job: complete immediately without going busy.
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // The final pop drains the last result; all results have
                // already been accepted, so the FIFO is empty afterwards.
                if (pop_s && ((emitted_r + RegDataWidth'(1)) == len_r)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            wr_ptr_r     <= {PtrW{1'b0}};
            rd_ptr_r     <= {PtrW{1'b0}};
            count_r      <= {CntW{1'b0}};
            beat_sel_r   <= 1'b0;
            len_r        <= {RegDataWidth{1'b0}};
            accepted_r   <= {RegDataWidth{1'b0}};
            emitted_r    <= {RegDataWidth{1'b0}};
            beat_count_r <= {RegDataWidth{1'b0}};
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= push_s ? wr_ptr_r + PtrW'(1) : wr_ptr_r;
            rd_ptr_r     <= pop_s  ? rd_ptr_r + PtrW'(1) : rd_ptr_r;
            count_r      <= count_s;
            beat_sel_r   <= beat_sel_s;
            len_r        <= len_s;
            accepted_r   <= accepted_s;
            emitted_r    <= emitted_s;
            beat_count_r <= beat_count_s;
            done_r       <= done_s;
        end
    end

    // FIFO storage; contents are only observed when the count marks them valid.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= res_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule
